// File: rtl/dispatch_credit_ctrl.sv
// dispatch_credit_ctrl: credit-based occupancy tracking for the ALU, branch,
// load/store and mult/div reservation stations and the ROB. Each class has a
// free-entry counter. Issued instructions charge credits and released entries
// return them. The registered counters drive the fullness flags that the
// issuer uses to stop.
// Optional feature: define CREDIT_CTRL_PERF_EN to add the o_stall_cycles
// performance counter.

package pkg_structures;
    // Instruction class as presented by the issuer.
    typedef enum logic [2:0] {
        AL = 3'd0,
        BR = 3'd1,
        LS = 3'd2,
        RB = 3'd3,
        MD = 3'd4,
        XX = 3'd5
    } instr_type_e;
endpackage

// One credit counter. The value is free entries, saturating at 0 and DEPTH.
module credit_ctr #(
    parameter int DEPTH = 8
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_flush,
    input  logic [1:0] i_charge,
    input  logic [1:0] i_release,
    output logic       o_full,
    output logic       o_viol
);
    localparam int W = $clog2(DEPTH + 1);
    localparam logic [W-1:0]        DEPTH_W = W'(DEPTH);
    localparam logic signed [W+1:0] DEPTH_S = (W+2)'(DEPTH);

    logic [W-1:0]        r_cr;
    logic signed [W+1:0] w_cur, w_chg, w_rel, w_next;
    logic                w_under, w_over;

    // Two extra bits cover both -2 and DEPTH+2 without wrapping.
    assign w_cur   = {2'b00, r_cr};
    assign w_chg   = {{W{1'b0}}, i_charge};
    assign w_rel   = {{W{1'b0}}, i_release};
    assign w_next  = w_cur - w_chg + w_rel;
    assign w_under = (w_next < 0);
    assign w_over  = (w_next > DEPTH_S);

    // A threshold of 2 lets two same-class issues in one cycle always fit.
    assign o_full  = (r_cr < W'(2));
    // A flush discards the update, so it cannot report a violation.
    assign o_viol  = !i_flush && (w_under || w_over);

    // Counter update. Flush refills the counter, otherwise it saturates at the bounds.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)   r_cr <= DEPTH_W;
        else if (i_flush) r_cr <= DEPTH_W;
        else if (w_under) r_cr <= '0;
        else if (w_over)  r_cr <= DEPTH_W;
        else              r_cr <= w_next[W-1:0];
    end
endmodule

module dispatch_credit_ctrl #(
    parameter int ALU_DEPTH = 8,
    parameter int BR_DEPTH  = 4,
    parameter int LS_DEPTH  = 8,
    parameter int MD_DEPTH  = 4,
    parameter int ROB_DEPTH = 16
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset_n,
    input  logic                                 i_flush,
    input  logic [1:0]                           i_issue_valid,
    input  pkg_structures::instr_type_e [1:0]    i_issue_type,
    input  logic [1:0]                           i_alu_release,
    input  logic [1:0]                           i_br_release,
    input  logic [1:0]                           i_ls_release,
    input  logic [1:0]                           i_md_release,
    input  logic [1:0]                           i_rob_release,
    output logic                                 o_full_alu,
    output logic                                 o_full_branch,
    output logic                                 o_full_load_store,
    output logic                                 o_full_mult_div,
    output logic                                 o_full_rob,
    output logic                                 o_credit_error
`ifdef CREDIT_CTRL_PERF_EN
    ,output logic [31:0]                         o_stall_cycles
`endif
);
    import pkg_structures::*;

    // Class index: 0 alu, 1 br, 2 ls, 3 md, 4 rob.
    localparam int NCLS = 5;

    logic [NCLS-1:0][1:0] w_charge;
    logic [NCLS-1:0][1:0] w_release;
    logic [NCLS-1:0]      w_full;
    logic [NCLS-1:0]      w_viol;
    logic                 r_err;

    assign w_release = {i_rob_release, i_md_release, i_ls_release, i_br_release, i_alu_release};

    // Charge per class. Every valid slot takes one ROB entry, and station classes also take one station entry.
    always_comb begin
        w_charge = '0;
        for (int s = 0; s < 2; s++) begin
            if (i_issue_valid[s]) begin
                w_charge[4] = w_charge[4] + 2'd1;
                case (i_issue_type[s])
                    AL:      w_charge[0] = w_charge[0] + 2'd1;
                    BR:      w_charge[1] = w_charge[1] + 2'd1;
                    LS:      w_charge[2] = w_charge[2] + 2'd1;
                    MD:      w_charge[3] = w_charge[3] + 2'd1;
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NCLS; g++) begin : g_cls
        localparam int DEP = (g == 0) ? ALU_DEPTH :
                             (g == 1) ? BR_DEPTH  :
                             (g == 2) ? LS_DEPTH  :
                             (g == 3) ? MD_DEPTH  : ROB_DEPTH;
        credit_ctr #(.DEPTH(DEP)) u_ctr (
            .i_clock   (i_clock),
            .i_reset_n (i_reset_n),
            .i_flush   (i_flush),
            .i_charge  (w_charge[g]),
            .i_release (w_release[g]),
            .o_full    (w_full[g]),
            .o_viol    (w_viol[g])
        );
    end

    // Sticky protocol-violation flag. Only reset clears it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)   r_err <= 1'b0;
        else if (|w_viol) r_err <= 1'b1;
    end

    assign o_full_alu        = w_full[0];
    assign o_full_branch     = w_full[1];
    assign o_full_load_store = w_full[2];
    assign o_full_mult_div   = w_full[3];
    assign o_full_rob        = w_full[4];
    assign o_credit_error    = r_err;

`ifdef CREDIT_CTRL_PERF_EN
    logic [31:0] r_stall;

    // Count cycles in which the issuer is throttled. Flush cycles are excluded and the count saturates.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_stall <= '0;
        else if (!i_flush && (|w_full) && (r_stall != 32'hFFFF_FFFF))
            r_stall <= r_stall + 32'd1;
    end

    assign o_stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Randomized scoreboard bench for dispatch_credit_ctrl. The driver works on
// negative edges and pushes the expected post-edge outputs from a free-entry
// model. The monitor pops one entry after each rising edge and compares it
// with the DUT outputs.
module tb_dispatch_credit_ctrl;
    import pkg_structures::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [1:0] issue_valid = '0;
    instr_type_e [1:0] issue_type;
    logic [1:0] alu_rel = '0, br_rel = '0, ls_rel = '0, md_rel = '0, rob_rel = '0;
    logic f_alu, f_br, f_ls, f_md, f_rob, cerr;
`ifdef CREDIT_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    dispatch_credit_ctrl dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
        .i_issue_valid(issue_valid), .i_issue_type(issue_type),
        .i_alu_release(alu_rel), .i_br_release(br_rel), .i_ls_release(ls_rel),
        .i_md_release(md_rel), .i_rob_release(rob_rel),
        .o_full_alu(f_alu), .o_full_branch(f_br), .o_full_load_store(f_ls),
        .o_full_mult_div(f_md), .o_full_rob(f_rob), .o_credit_error(cerr)
`ifdef CREDIT_CTRL_PERF_EN
        , .o_stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic [4:0]  full;
        logic        err;
        logic [31:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Model state: free entries per class (0 alu, 1 br, 2 ls, 3 md, 4 rob).
    int depth[5] = '{8, 4, 8, 4, 16};
    int cr[5];
    bit m_err;
    longint m_stall;

    // Stimulus for the next cycle.
    bit          st_fl;
    bit [1:0]    st_v;
    instr_type_e st_t[2];
    int          st_rel[5];

    function automatic int class_of(instr_type_e t);
        case (t)
            AL: return 0;
            BR: return 1;
            LS: return 2;
            MD: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [4:0] model_full();
        logic [4:0] f;
        for (int c = 0; c < 5; c++) f[c] = (cr[c] < 2);
        return f;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 5; c++) cr[c] = depth[c];
        m_err = 0;
        m_stall = 0;
    endtask

    task automatic clear_stim();
        st_fl = 0;
        st_v = '0;
        st_t[0] = AL;
        st_t[1] = AL;
        for (int c = 0; c < 5; c++) st_rel[c] = 0;
    endtask

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model by one edge, and push the expected outputs.
    task automatic cycle();
        exp_t e;
        int ch[5];
        int n;
        flush = st_fl;
        issue_valid = st_v;
        issue_type[0] = st_t[0];
        issue_type[1] = st_t[1];
        alu_rel = 2'(st_rel[0]);
        br_rel  = 2'(st_rel[1]);
        ls_rel  = 2'(st_rel[2]);
        md_rel  = 2'(st_rel[3]);
        rob_rel = 2'(st_rel[4]);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!st_fl && (model_full() != 0) && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (st_fl) begin
                for (int c = 0; c < 5; c++) cr[c] = depth[c];
            end else begin
                for (int c = 0; c < 5; c++) ch[c] = 0;
                for (int s = 0; s < 2; s++)
                    if (st_v[s]) begin
                        ch[4]++;
                        if (class_of(st_t[s]) != 4) ch[class_of(st_t[s])]++;
                    end
                for (int c = 0; c < 5; c++) begin
                    n = cr[c] - ch[c] + st_rel[c];
                    if (n < 0) begin n = 0; m_err = 1; end
                    else if (n > depth[c]) begin n = depth[c]; m_err = 1; end
                    cr[c] = n;
                end
            end
        end
        e.full  = model_full();
        e.err   = m_err;
        e.stall = 32'(m_stall);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clear_stim();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic issue2(input bit [1:0] v, input instr_type_e t0, input instr_type_e t1);
        clear_stim();
        st_v = v;
        st_t[0] = t0;
        st_t[1] = t1;
    endtask

    // Asserts reset away from any clock edge and checks the outputs clear at once.
    task automatic do_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_full", {f_rob, f_md, f_ls, f_br, f_alu}, 0);
        chk("async_reset_err", cerr, 0);
        @(negedge clk);
        clear_stim();
        for (int i = 0; i < cycles; i++) cycle();
        rst_n = 1'b1;
    endtask

    // Monitor: after each rising edge, compare the outputs with the next expected entry.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("fullness", {f_rob, f_md, f_ls, f_br, f_alu}, e.full);
            chk("credit_error", cerr, e.err);
`ifdef CREDIT_CTRL_PERF_EN
            chk("stall_cycles", stall_cycles, e.stall);
`endif
        end
    end

    initial begin
        int mx, occ, cls;
        instr_type_e t;
        issue_type[0] = AL;
        issue_type[1] = AL;
        model_reset();
        clear_stim();
        @(negedge clk);
        do_reset(2);
        idle(3);

        // Branch charge, then charge and release in the same cycle, then a release back below the threshold.
        issue2(2'b11, BR, BR); cycle();
        issue2(2'b01, BR, AL); cycle();
        issue2(2'b01, BR, AL); st_rel[1] = 1; cycle();
        clear_stim(); st_rel[1] = 2; cycle();
        idle(1);

        // Only the ROB is charged for XX and RB, down to rob_cr == 1.
        do_reset(1);
        for (int i = 0; i < 7; i++) begin issue2(2'b11, XX, RB); cycle(); end
        issue2(2'b01, XX, RB); cycle();
        idle(2);

        // Mult/div underflow, ALU overflow at DEPTH, and the sticky error.
        do_reset(1);
        for (int i = 0; i < 2; i++) begin issue2(2'b11, MD, MD); cycle(); end
        issue2(2'b01, MD, AL); cycle();
        clear_stim(); st_rel[0] = 2; cycle();
        idle(4);

        // Flush with concurrent issue and release.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin issue2(2'b11, LS, AL); cycle(); end
        issue2(2'b11, BR, BR); cycle();
        issue2(2'b11, AL, LS); st_rel[4] = 2; st_rel[1] = 1; st_fl = 1; cycle();
        idle(3);

        // Randomized traffic. Issues respect the model's fullness, releases never exceed occupancy, with rare forced violations.
        do_reset(1);
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset(2);
            clear_stim();
            st_fl = ($urandom_range(0, 59) == 0);
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 3) != 0) begin
                    t = instr_type_e'($urandom_range(0, 5));
                    cls = class_of(t);
                    if (cr[4] >= 2 && (cls == 4 || cr[cls] >= 2)) begin
                        st_v[s] = 1'b1;
                        st_t[s] = t;
                    end
                end
            end
            for (int c = 0; c < 5; c++) begin
                occ = depth[c] - cr[c];
                mx = (occ < 2) ? occ : 2;
                if (c == 4 || $urandom_range(0, 2) == 0) st_rel[c] = $urandom_range(0, mx);
            end
            if ($urandom_range(0, 499) == 0) st_rel[$urandom_range(0, 4)] = 2;
            cycle();
        end
        idle(2);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dispatch_credit_ctrl.md
# dispatch_credit_ctrl

Credit-based occupancy controller for the dispatch stage. Tracks free entries in the ALU, branch, load/store and mult/div reservation stations and in the ROB. Charges credits for every instruction the issuer forwards and returns them when entries are released. Drives the fullness bus that the issuer turns into its stop signal, so the issuer never forwards an instruction with no free slot.

## Interface
Parameters:
- ALU_DEPTH, 8, ALU station entries
- BR_DEPTH, 4, branch station entries
- LS_DEPTH, 8, load/store station entries
- MD_DEPTH, 4, mult/div station entries
- ROB_DEPTH, 16, ROB entries
- All depths are at least 2.

Ports:
- clock, in, 1: the single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low.
- flush, in, 1: pipeline flush; stations and ROB are emptied.
- issue_valid[2], in, 1 each: slot i forwarded an instruction this cycle.
- issue_type[2], in, pkg_structures instr type each: class of slot i (AL, BR, LS, RB, MD, XX).
- alu_release, br_release, ls_release, md_release, in, 2 each: entries freed this cycle, 0..2.
- rob_release, in, 2: ROB entries committed this cycle, 0..2.
- fullness, fullness_bus_if source: alu, branch, load_store, mult_div, rob flags.
- credit_error, out, 1: sticky protocol-violation flag.

## Operation
- Each class has a counter: alu_cr, br_cr, ls_cr, md_cr, rob_cr. The width is $clog2(DEPTH+1).
- Counters hold free entries.
- Charging for each valid slot:
  - AL, BR, LS and MD charge one credit of their station plus one ROB credit.
  - RB and XX charge one ROB credit only.
- Per-cycle update per class: next = cur - charged + released.
  - charged is 0..2 and released is 0..2; both are applied in the same cycle.
  - Compute the update in width+2 signed arithmetic.
- Underflow: if next < 0, the counter saturates at 0 and credit_error is set.
- Overflow: if next > DEPTH, the counter saturates at DEPTH and credit_error is set.
- flush has priority over everything. All counters load DEPTH. Charges and releases in that cycle are ignored. credit_error is unchanged.
- Fullness flag per class is asserted when the counter is < 2. This threshold guarantees that two same-class instructions issued in one cycle always fit.
- credit_error is sticky and cleared only by reset.

## Timing
- Reset (async assert): all counters = DEPTH, every fullness flag = 0, credit_error = 0. This applies even mid-operation.
- Fullness is combinational from the registered counters only. There is no combinational path from issue_* or *_release to fullness.
- Latency: an issue or release at edge N is visible in counters and fullness after edge N (one cycle).
- Simultaneous charge and release of the same class net out in one update. Example: cr=1, charge 1, release 1 gives cr=1, and fullness stays asserted.
- Deassertion of reset is synchronised externally; the block has no reset synchronizer.

## Configuration
- CREDIT_CTRL_PERF_EN defined:
  - Adds output stall_cycles, 32 bits, reset to 0.
  - It increments every cycle in which any fullness flag is asserted and flush is low.
  - It saturates at 0xFFFF_FFFF.
- CREDIT_CTRL_PERF_EN undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset then idle -> all counters at DEPTH (8/4/8/4/16), all fullness 0, credit_error 0.
- Issue BR+BR for 1 cycle, then BR for 1 cycle (BR_DEPTH=4) -> br_cr 4→2→1; branch fullness rises after the second edge; rob_cr 16→14→13.
- br_cr=1: charge BR and br_release=1 in the same cycle -> br_cr stays 1, fullness stays 1; next cycle br_release=2 -> br_cr=3, fullness 0.
- Issue XX+RB repeatedly -> only rob_cr decrements; rob fullness asserts at rob_cr=1; station counters stay at DEPTH.
- md_cr=0 with an MD issue -> md_cr stays 0 and credit_error=1; alu_release=2 at alu_cr=8 -> alu_cr stays 8; credit_error remains 1 until reset.
- Mid-run flush with concurrent issue and release -> all counters return to DEPTH next cycle. Under CREDIT_CTRL_PERF_EN, stall_cycles does not count the flush cycle.
